alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one instance of the team's `ALU` datapath between two independent requesters, for example the execute sequencer and an address-generation unit. It uses a request/grant/done handshake and round-robin arbitration. The winner's operation and operands are captured into internal registers and executed over one cycle. The result, carry and zero flag are returned registered, together with a one-cycle done pulse to the winning port.

## Interface
- `W`, default 32: datapath width; passed to the internal `ALU`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` input 1: port 0 requests an operation.
- `op0` input 3: port 0 ALUOp.
- `a0` input W: port 0 first operand (R2).
- `b0` input W: port 0 second operand (R3).
- `req1`, `op1`, `a1`, `b1`: same as the port 0 signals, for port 1.
- `gnt0` output 1: one-cycle pulse; port 0 operands have been captured.
- `gnt1` output 1: one-cycle pulse; port 1 operands have been captured.
- `done0` output 1: one-cycle pulse; `result`/`c_out`/`zero` are valid for port 0.
- `done1` output 1: one-cycle pulse; same for port 1.
- `result` output W: registered ALU result.
- `c_out` output 1: registered ALU carry; meaningful only for ADD and SUB, 0 otherwise.
- `zero` output 1: registered, 1 when `result` == 0.
- `busy` output 1: high while state is EXEC.

## Operation
- ALUOp encoding:
  - 0 MOV
  - 1 NOT
  - 2 ADD
  - 3 SUB
  - 4 OR
  - 5 AND
  - 6 constant 0
  - 7 SLT (signed)
- The ALU is driven only from the internal registers `op_q`, `a_q`, `b_q`. It never sees the port inputs directly.
- FSM states are IDLE and EXEC.
  - **IDLE:** if `req0` or `req1` is high at the clock edge, select the winner, load `op_q`/`a_q`/`b_q` from the winner's port, record the winner in `owner_q`, and go to EXEC. With no request, stay in IDLE.
  - **EXEC:** at the next edge, load `result`/`c_out`/`zero` from the ALU outputs and go to IDLE unconditionally.
- Arbitration:
  - `last_q` is reset to 1, so port 0 wins the first contention.
  - If only one port requests, that port wins.
  - If both ports request, the winner is the port that is not `last_q`.
  - `last_q` is updated to the winner on every grant.
- Requests are sampled only in IDLE. `req` and the port's operands must be held stable until the matching `gnt` pulse.
- A port that still has `req` high in its done cycle is treated as issuing a new operation, and competes again at that edge.
- `result`, `c_out` and `zero` hold their values until the next EXEC completes.
- Reset values:
  - State IDLE.
  - `gnt0`, `gnt1`, `done0`, `done1`, `busy`, `c_out`: 0.
  - `result`: 0.
  - `zero`: 0.
  - `op_q`, `a_q`, `b_q`: 0.
  - `last_q`: 1.
- Reset asserted mid-operation: the operation is aborted and no done pulse is ever produced for it. After reset is released, the first request is treated as fresh.
- Arithmetic: all arithmetic is W bits and wraps modulo 2^W. SLT compares signed values. `zero` is computed from the W-bit result.

## Timing
- Edge k, in IDLE with a request: operands are captured. During cycle k→k+1, `gnt` of the winning port is high and `busy` is high.
- Edge k+1: the result is registered. During cycle k+1→k+2, `done` of the winning port is high and `busy` is low.
- Edge k+2: a new request may be accepted.
- Peak throughput is one operation every 2 cycles. Latency from capture to done is 1 cycle.
- At most one of `gnt0`/`gnt1` is high in any cycle. At most one of `done0`/`done1` is high in any cycle. No `gnt` and `done` are high in the same cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins when both ports request. `last_q` is not implemented, and port 1 may starve.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default): round-robin arbitration as specified under Operation.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → all outputs go to their reset values immediately. Release `rst` with no requests → outputs stay at reset values and `busy`=0.
- **Single ADD with carry:** `req0`, `op0`=2, `a0`=0xFFFFFFFF, `b0`=1 → `gnt0` one cycle after the sampling edge, then `done0`, `result`=0, `c_out`=1, `zero`=1.
- **SUB then SLT:** `req1`, `op1`=3, `a1`=5, `b1`=7 → `result`=0xFFFFFFFE, `c_out`=0. Then `op1`=7, `a1`=0xFFFFFFFF, `b1`=1 → `result`=1.
- **Contention:** both ports request continuously with distinct ops → grant order 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` defined → grant order 0,0,0.
- **Reset mid-op:** pulse `rst` during the EXEC cycle of a port 0 ADD → no `done0` pulse. The next `req1` is granted first, because `last_q`=1 after reset prefers port 0 only on contention.
- **Back-to-back:** `req0` held high across 3 operations → a grant every 2 cycles, with `busy` toggling 1,0,1,0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one registered ALU
//
// Purpose:
//   Shares a single ALU datapath between two requesters (port 0 and port 1).
//   In IDLE a requesting port wins arbitration. Its op and operands are captured
//   into op_q/a_q/b_q, and the FSM moves to EXEC. At the next edge the ALU output
//   is registered, done is pulsed to the owner, and the FSM returns to IDLE.
//   Peak throughput is one operation every two cycles.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - when defined, port 0 always wins contention and
//                           no last_q register exists. When undefined
//                           (default), arbitration is round-robin.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req0/op0/a0/b0     port 0 request, ALUOp, operands
//   req1/op1/a1/b1     port 1 request, ALUOp, operands
//   gnt0/gnt1          one-cycle pulse: operands of that port were captured
//   done0/done1        one-cycle pulse: result/c_out/zero valid for that port
//   result             registered ALU result (W bits)
//   c_out              registered carry (ADD/SUB only, else 0)
//   zero               registered result == 0
//   busy               high while the FSM is in EXEC

// ALUOp: 0 MOV(a) 1 NOT(a) 2 ADD 3 SUB 4 OR 5 AND 6 zero 7 SLT(signed)
module alu #(
  parameter int W = 32
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         c_out
);

  logic [W:0] sum;
  logic [W:0] diff;

  // SUB is computed as a + ~b + 1, so its carry is the "no borrow" flag.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    c_out  = 1'b0;
    case (op)
      3'd0: result = a;
      3'd1: result = ~a;
      3'd2: begin
        result = sum[W-1:0];
        c_out  = sum[W];
      end
      3'd3: begin
        result = diff[W-1:0];
        c_out  = diff[W];
      end
      3'd4: result = a | b;
      3'd5: result = a & b;
      3'd6: result = '0;
      3'd7: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t       state;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         owner_q;   // 0: port 0 owns the operation in flight, 1: port 1
  logic         pick1;     // port 1 wins if a capture happens this edge

  logic [W-1:0] alu_result;
  logic         alu_c_out;

  // The ALU sees only the captured registers, never the port inputs.
  alu #(.W(W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .c_out  (alu_c_out)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Port 0 always wins contention. Port 1 may starve.
  assign pick1 = req1 & ~req0;
`else
  logic last_q;  // most recent winner. Reset to 1 so port 0 wins the first tie.

  // With contention, the port that did not win last time is chosen.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last_q <= pick1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      owner_q <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      c_out   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      // All handshake outputs are single-cycle pulses.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_q    <= pick1 ? op1 : op0;
            a_q     <= pick1 ? a1  : a0;
            b_q     <= pick1 ? b1  : b0;
            owner_q <= pick1;
            gnt0    <= ~pick1;
            gnt1    <= pick1;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_result;
          c_out  <= alu_c_out;
          zero   <= (alu_result == '0);
          done0  <= ~owner_q;
          done1  <= owner_q;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, c_out, zero, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .c_out(c_out), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference ALU, computed directly from the operation definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c);
    longint ua, ub, s;
    ua = longint'(a);
    ub = longint'(b);
    c = 1'b0;
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: begin s = ua + ub; r = s[31:0]; c = (s >= 64'sh1_0000_0000); end
      3'd3: begin s = ua - ub; r = s[31:0]; c = (ua >= ub); end
      3'd4: r = a | b;
      3'd5: r = a & b;
      3'd6: r = 32'd0;
      default: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endcase
  endtask

  task automatic drive(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 0);
    chk({tag, "_gnt1"}, 32'(gnt1), 0);
    chk({tag, "_done0"}, 32'(done0), 0);
    chk({tag, "_done1"}, 32'(done1), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_c_out"}, 32'(c_out), 0);
    chk({tag, "_zero"}, 32'(zero), 0);
  endtask

  // Single uncontended operation: request at a negedge, gnt the next cycle, done the one after.
  task automatic run_single(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.port, v.op, v.a, v.b);
    @(negedge clk);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(v.port == 0));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(v.port == 1));
    chk({tag, "_busy_exec"}, 32'(busy), 1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_done0"}, 32'(done0), 32'(v.port == 0));
    chk({tag, "_done1"}, 32'(done1), 32'(v.port == 1));
    chk({tag, "_busy_done"}, 32'(busy), 0);
    chk({tag, "_result"}, result, v.exp_r);
    chk({tag, "_c_out"}, 32'(c_out), 32'(v.exp_c));
    chk({tag, "_zero"}, 32'(zero), 32'(v.exp_z));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] er;
    logic        ec;
    logic [31:0] hold_r;
    int          last_w;
    int          w;

    vecs.push_back('{0, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{1, 3'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{1, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{0, 3'd3, 32'd7, 32'd5, 32'd2, 1'b1, 1'b0});
    vecs.push_back('{1, 3'd2, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0});
    vecs.push_back('{0, 3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0});
    vecs.push_back('{1, 3'd1, 32'h0000_0000, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{0, 3'd4, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0});
    vecs.push_back('{1, 3'd5, 32'hF0F0_FFFF, 32'h0F0F_00FF, 32'h0000_00FF, 1'b0, 1'b0});
    vecs.push_back('{0, 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{1, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{0, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{1, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0, 1'b0});

    // Reset held from time 0, then released with no requests.
    #12;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_idle");

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++)
      run_single($sformatf("vec%0d", i), vecs[i]);

    // Result holds while idle.
    @(negedge clk);
    chk("hold_result", result, 32'hA5A5_5A5A);
    chk("hold_done1", 32'(done1), 0);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention from a fresh reset.
    @(negedge clk);
    drive(0, 3'd2, 32'd10, 32'd20);
    drive(1, 3'd3, 32'd100, 32'd1);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = i % 2;
`endif
      @(negedge clk);
      chk($sformatf("cont%0d_gnt0", i), 32'(gnt0), 32'(w == 0));
      chk($sformatf("cont%0d_gnt1", i), 32'(gnt1), 32'(w == 1));
      @(negedge clk);
      chk($sformatf("cont%0d_done0", i), 32'(done0), 32'(w == 0));
      chk($sformatf("cont%0d_done1", i), 32'(done1), 32'(w == 1));
      chk($sformatf("cont%0d_result", i), result, (w == 0) ? 32'd30 : 32'd99);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Back-to-back on port 0: operand set n is presented until its grant.
    @(negedge clk);
    drive(0, 3'd2, 32'd1, 32'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_gnt0", n), 32'(gnt0), 1);
      chk($sformatf("b2b%0d_busy1", n), 32'(busy), 1);
      chk($sformatf("b2b%0d_done0_low", n), 32'(done0), 0);
      drive(0, 3'd2, 32'(n + 2), 32'd1);
      if (n == 2) req0 = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d_busy0", n), 32'(busy), 0);
      chk($sformatf("b2b%0d_gnt0_low", n), 32'(gnt0), 0);
      chk($sformatf("b2b%0d_done0", n), 32'(done0), 1);
      chk($sformatf("b2b%0d_result", n), result, 32'(n + 2));
    end
    @(negedge clk);
    chk("b2b_stop_gnt0", 32'(gnt0), 0);
    chk("b2b_stop_busy", 32'(busy), 0);

    // Reset during EXEC of a port 0 ADD aborts it.
    do_reset();
    @(negedge clk);
    drive(0, 3'd2, 32'd3, 32'd4);
    @(negedge clk);
    chk("abort_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_no_done0_%0d", i), 32'(done0), 0);
      chk($sformatf("abort_no_done1_%0d", i), 32'(done1), 0);
      @(negedge clk);
    end
    chk("abort_result", result, 0);
    run_single("abort_next", '{1, 3'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0});

    // Randomized operations against the reference model.
    do_reset();
    last_w = 1;
    for (int i = 0; i < 200; i++) begin
      logic r0, r1;
      logic [2:0] o0, o1;
      logic [31:0] x0, y0, x1, y1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      o0 = 3'($urandom_range(0, 7)); o1 = 3'($urandom_range(0, 7));
      x0 = rand_operand(); y0 = rand_operand();
      x1 = rand_operand(); y1 = rand_operand();
      if (r0 && r1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last_w == 1) ? 0 : 1;
`endif
      end else begin
        w = r0 ? 0 : 1;
      end
      last_w = w;
      if (w == 0) model(o0, x0, y0, er, ec);
      else        model(o1, x1, y1, er, ec);
      @(negedge clk);
      if (r0) drive(0, o0, x0, y0);
      if (r1) drive(1, o1, x1, y1);
      @(negedge clk);
      chk($sformatf("rnd%0d_gnt0", i), 32'(gnt0), 32'(w == 0));
      chk($sformatf("rnd%0d_gnt1", i), 32'(gnt1), 32'(w == 1));
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk($sformatf("rnd%0d_done0", i), 32'(done0), 32'(w == 0));
      chk($sformatf("rnd%0d_done1", i), 32'(done1), 32'(w == 1));
      chk($sformatf("rnd%0d_result", i), result, er);
      chk($sformatf("rnd%0d_c_out", i), 32'(c_out), 32'(ec));
      chk($sformatf("rnd%0d_zero", i), 32'(zero), 32'(er == 0));
      if ($urandom_range(0, 3) == 0) begin
        hold_r = er;
        @(negedge clk);
        chk($sformatf("rnd%0d_hold", i), result, hold_r);
        chk($sformatf("rnd%0d_idle_busy", i), 32'(busy), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
